product_accumulator: RTL and testbench
======================================

// Module: product_accumulator
// PURPOSE
//  Downstream consumer of the 8x8 multiplier's 16-bit product stream.
//  Accepts products over a valid/ready handshake and sums each group of N
//  consecutive products into a saturating AW-bit accumulator.
//  Presents the group sum with a sticky overflow flag on a valid/ready output.
//  This gives the multiplier family a dot-product / MAC back end.
// PARAMETERS
//  PW  16  product (input) width; matches multiplier output width
//  N   4   products per group, 2..16
//  AW  17  accumulator/output width, >= PW; sums above 2^AW-1 saturate
// PORTS
//  clk        in   1   single clock, all state on rising edge
//  rst        in   1   asynchronous reset, active-high
//  clr        in   1   sync abort: discards the partial group and any pending result
//  in_valid   in   1   in_prod valid this cycle
//  in_ready   out  1   block can accept a product this cycle
//  in_prod    in   PW  unsigned product from the multiplier
//  out_valid  out  1   out_sum/out_ovf hold a completed group result
//  out_ready  in   1   consumer accepts the result
//  out_sum    out  AW  unsigned group sum, saturated
//  out_ovf    out  1   1 = at least one add in this group saturated
// BEHAVIOUR
//  - Reset (async, rst=1): state=IDLE; in_ready=0, out_valid=0, out_sum=0,
//    out_ovf=0, acc=0, cnt=0. All outputs are registered.
//  - States: IDLE -> ACC -> DONE -> ACC ...
//  - IDLE: lasts exactly one clock after rst deasserts; then ACC with in_ready=1.
//  - ACC: in_ready=1. On an edge with in_valid&in_ready:
//    acc <= sat(acc + in_prod); ovf |= carry; cnt++.
//    sat() clamps to 2^AW-1.
//  - Group end: when the accepted product has cnt==N-1, the next edge loads
//    out_sum=final sum and out_ovf=final ovf. It also sets out_valid=1 and
//    in_ready=0, clears acc/cnt/ovf, and enters DONE.
//    Latency: last product accepted -> out_valid high on the following edge.
//  - DONE: out_sum/out_ovf stay stable. in_valid is ignored; no product is
//    consumed. On out_valid&out_ready: out_valid=0, in_ready=1, back to ACC.
//    Peak throughput is N products per N+1 cycles.
//  - in_valid=0 in ACC: acc/cnt hold. Gaps between products are allowed.
//  - Zero products are accepted and counted (sum unchanged).
//  - clr (sync) has priority over every other event on the same edge:
//    acc=0, cnt=0, ovf=0, out_valid=0, in_ready=1, state=ACC.
//    out_sum keeps its last value. A product presented with clr is dropped.
//    A pending DONE result is discarded even when out_ready=1 on that edge.
//  - rst mid-group or mid-DONE: immediate return to the reset values above,
//    independent of clk.
//  - cnt is $clog2(N) bits and wraps only via group end, never by overflow.
// STRUCTURE
//  - Shared package: state encoding IDLE=2'd0, ACC=2'd1, DONE=2'd2.
//    Also the default widths PW=16 and AW=17, shared with the multipliers.
//  - One sub-module, sat_adder #(AW): unsigned a+b with clamp to all-ones and
//    a carry flag. Purely combinational.
//  - The FSM, counter and output registers live in product_accumulator.
// TESTING (N=4, AW=17; products taken from the multiplier bench operands)
//  1. After reset, stream 50, 700, 40000, 990 back-to-back
//     -> out_valid one edge after 990, out_sum=41740, out_ovf=0.
//  2. Stream 40000 x3 then 990
//     -> out_sum=120990, out_ovf=0.
//     Stream 65025 x4 -> out_sum=131071, out_ovf=1.
//  3. Hold out_ready=0 for 5 cycles in DONE while in_valid=1 with 13464
//     -> out_sum stable and in_ready=0 throughout.
//     13464 is not counted; the next group starts clean after out_ready.
//  4. Accept 700 and 50, then pulse clr with in_valid=1 and in_prod=990
//     -> 990 is dropped. A following group 1,2,3,4 gives out_sum=10.
//  5. Assert rst between clock edges after 2 products
//     -> outputs go to reset values immediately.
//     in_ready rises 2 edges after release; the next group is unaffected.
//  6. Insert random in_valid gaps inside the group 10,20,30,40
//     -> out_sum=100, and out_valid rises exactly once.

Source files
------------

// File: rtl/product_accumulator_pkg.sv
// -----------------------------------------------------------------------------
// product_accumulator_pkg
//   Shared definitions for the product accumulator and the multiplier family:
//   default product/accumulator widths and the accumulator FSM state encoding.
// -----------------------------------------------------------------------------
package product_accumulator_pkg;

    // Default widths shared with the 8x8 multipliers (16-bit product stream).
    localparam int PW_DEFAULT = 16;
    localparam int AW_DEFAULT = 17;

    // FSM encoding kept as plain constants so legacy tools and waveform
    // viewers see stable numeric state values.
    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_ACC  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage : product_accumulator_pkg

// File: rtl/product_accumulator_if.sv
// -----------------------------------------------------------------------------
// product_accumulator_if
//   Product input stream plus group-result output stream of the accumulator.
//   Ports (signals):
//     in_valid  / in_ready / in_prod   product stream (producer -> accumulator)
//     out_valid / out_ready            result handshake (accumulator -> consumer)
//     out_sum   / out_ovf              saturated group sum and sticky overflow
//   Modports:
//     master  the environment: drives products, accepts results
//     slave   the accumulator itself
// -----------------------------------------------------------------------------
interface product_accumulator_if
    import product_accumulator_pkg::*;
#(
    parameter int PW = PW_DEFAULT,
    parameter int AW = AW_DEFAULT
);

    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_prod;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_sum;
    logic          out_ovf;

    modport master (
        output in_valid,
        output in_prod,
        input  in_ready,
        input  out_valid,
        input  out_sum,
        input  out_ovf,
        output out_ready
    );

    modport slave (
        input  in_valid,
        input  in_prod,
        output in_ready,
        output out_valid,
        output out_sum,
        output out_ovf,
        input  out_ready
    );

endinterface : product_accumulator_if

// File: rtl/product_accumulator_sat_adder.sv
// -----------------------------------------------------------------------------
// sat_adder
//   Purely combinational unsigned adder that clamps to all-ones on overflow.
//   Ports:
//     a, b   in   AW  unsigned operands
//     sum    out  AW  a+b, or 2^AW-1 when the true sum does not fit
//     carry  out  1   1 = the true sum did not fit (clamping happened)
// -----------------------------------------------------------------------------
module sat_adder #(
    parameter int AW = 17
) (
    input  logic [AW-1:0] a,
    input  logic [AW-1:0] b,
    output logic [AW-1:0] sum,
    output logic          carry
);

    logic [AW:0] full;

    // NOTE: combinational blocks use blocking '=' and assign every output on
    // every path, so no latch can be inferred.
    always_comb begin
        full  = {1'b0, a} + {1'b0, b};
        carry = full[AW];
        sum   = carry ? {AW{1'b1}} : full[AW-1:0];
    end

endmodule : sat_adder

// File: rtl/product_accumulator.sv
// -----------------------------------------------------------------------------
// product_accumulator
//   Back end for the multiplier family: accepts a stream of unsigned products,
//   sums each group of N consecutive products into a saturating AW-bit
//   accumulator and presents the group sum plus a sticky overflow flag.
//   Ports:
//     clk   in   1   rising-edge clock
//     rst   in   1   asynchronous reset, active-high
//     clr   in   1   synchronous abort of the partial group and pending result
//     bus   slave    product stream in, group result out (product_accumulator_if)
//   All interface outputs come straight from registers.
// -----------------------------------------------------------------------------
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int PW = PW_DEFAULT,
    parameter int N  = 4,
    parameter int AW = AW_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    product_accumulator_if.slave bus
);

    localparam int            CW       = $clog2(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    state_t        state;
    logic          idle_seen;   // first clock after reset release has passed
    logic [CW-1:0] cnt;
    logic [AW-1:0] acc;
    logic          ovf;

    logic          in_ready_q;
    logic          out_valid_q;
    logic [AW-1:0] out_sum_q;
    logic          out_ovf_q;

    logic [AW-1:0] sum_next;
    logic          carry;
    logic          accept;

    assign accept = bus.in_valid & in_ready_q;

    sat_adder #(.AW(AW)) u_sat_adder (
        .a     (acc),
        .b     (AW'(bus.in_prod)),
        .sum   (sum_next),
        .carry (carry)
    );

    // NOTE: sequential state is written only with non-blocking '<=' so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            idle_seen   <= 1'b0;
            cnt         <= '0;
            acc         <= '0;
            ovf         <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else if (clr) begin
            // Abort wins over everything, including a same-edge result
            // handshake; out_sum keeps its last value on purpose.
            state       <= ST_ACC;
            cnt         <= '0;
            acc         <= '0;
            ovf         <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // IDLE spans one full clock after reset release before
                    // the block starts accepting products.
                    if (idle_seen) begin
                        state      <= ST_ACC;
                        in_ready_q <= 1'b1;
                    end else begin
                        idle_seen  <= 1'b1;
                    end
                end

                ST_ACC: begin
                    if (accept) begin
                        if (cnt == CNT_LAST) begin
                            // Last product of the group: publish the result on
                            // the accepting edge and start the next group clean.
                            out_sum_q   <= sum_next;
                            out_ovf_q   <= ovf | carry;
                            out_valid_q <= 1'b1;
                            in_ready_q  <= 1'b0;
                            acc         <= '0;
                            cnt         <= '0;
                            ovf         <= 1'b0;
                            state       <= ST_DONE;
                        end else begin
                            acc <= sum_next;
                            ovf <= ovf | carry;
                            cnt <= cnt + 1'b1;
                        end
                    end
                end

                ST_DONE: begin
                    // in_valid is ignored here: in_ready is low throughout.
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= ST_ACC;
                    end
                end

                default: begin
                    state       <= ST_IDLE;
                    idle_seen   <= 1'b0;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_ovf   = out_ovf_q;

endmodule : product_accumulator

// File: tb/tb_product_accumulator.sv
// -----------------------------------------------------------------------------
// tb_product_accumulator
//   Directed bench for product_accumulator (N=4, AW=17). A reference model
//   computes each group's saturated sum; results are queued when the last
//   product of a group is accepted and compared when the DUT hands them over.
// -----------------------------------------------------------------------------
module tb_product_accumulator;

    localparam int PW  = 16;
    localparam int N   = 4;
    localparam int AW  = 17;
    localparam int MAX = (1 << AW) - 1;

    typedef struct {
        logic [AW-1:0] sum;
        logic          ovf;
    } result_t;

    logic clk = 1'b0;
    logic rst;
    logic clr;

    always #5 clk = ~clk;

    product_accumulator_if #(.PW(PW), .AW(AW)) bus ();

    product_accumulator #(.PW(PW), .N(N), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .bus (bus)
    );

    result_t sb[$];
    int      tests = 0;
    int      fails = 0;
    int      mdl_acc;
    int      mdl_cnt;
    bit      mdl_ovf;
    int      rises = 0;
    logic    prev_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        mdl_acc = 0;
        mdl_cnt = 0;
        mdl_ovf = 1'b0;
    endtask

    // Present one product, wait (bounded) for in_ready, let one edge accept it
    // and advance the reference model.
    task automatic send(input int p);
        int budget;
        budget       = 0;
        bus.in_prod  = PW'(p);
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && budget < 50) begin
            tick();
            budget++;
        end
        if (bus.in_ready !== 1'b1) begin
            check("send_ready_timeout", {31'd0, bus.in_ready}, 32'd1);
            bus.in_valid = 1'b0;
            return;
        end
        tick();
        bus.in_valid = 1'b0;
        mdl_acc = mdl_acc + p;
        if (mdl_acc > MAX) begin
            mdl_acc = MAX;
            mdl_ovf = 1'b1;
        end
        mdl_cnt++;
        if (mdl_cnt == N) begin
            sb.push_back('{sum: AW'(mdl_acc), ovf: mdl_ovf});
            model_clear();
        end
    endtask

    // Release reset between edges; in_ready must stay low on the first edge
    // and rise on the second.
    task automatic release_reset(input string tag);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check({tag, "_edge1_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
        tick();
        check({tag, "_edge2_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    endtask

    // Result monitor: one transfer per cycle where valid&ready and no abort.
    always @(negedge clk) begin
        result_t exp;
        if (rst === 1'b1) begin
            prev_valid = 1'b0;
        end else begin
            if (bus.out_valid === 1'b1 && prev_valid !== 1'b1) rises++;
            prev_valid = bus.out_valid;
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1 && clr !== 1'b1) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $error("FAIL sb_unexpected: observed result %0d with nothing expected", bus.out_sum);
                end else begin
                    exp = sb.pop_front();
                    check("out_sum", 32'(bus.out_sum), 32'(exp.sum));
                    check("out_ovf", {31'd0, bus.out_ovf}, {31'd0, exp.ovf});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int gap;
        rst           = 1'b1;
        clr           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_prod   = '0;
        bus.out_ready = 1'b1;
        model_clear();

        // Reset state
        #12;
        check("rst_in_ready",  {31'd0, bus.in_ready},  32'd0);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_out_sum",   32'(bus.out_sum),       32'd0);
        check("rst_out_ovf",   {31'd0, bus.out_ovf},   32'd0);
        release_reset("rst0");

        // 1: back-to-back group, result one edge after the last product
        send(50);
        send(700);
        send(40000);
        send(990);
        check("t1_out_valid", {31'd0, bus.out_valid}, 32'd1);
        check("t1_in_ready",  {31'd0, bus.in_ready},  32'd0);

        // 2: large sums, then saturation
        send(40000);
        send(40000);
        send(40000);
        send(990);
        send(65025);
        send(65025);
        send(65025);
        send(65025);
        check("t2_ovf_direct", {31'd0, bus.out_ovf}, 32'd1);
        tick();

        // 3: back-pressure in DONE while a product is offered
        bus.out_ready = 1'b0;
        send(100);
        send(200);
        send(300);
        send(400);
        bus.in_valid = 1'b1;
        bus.in_prod  = 16'd13464;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_hold_out_valid", {31'd0, bus.out_valid}, 32'd1);
            check("t3_hold_in_ready",  {31'd0, bus.in_ready},  32'd0);
            check("t3_hold_out_sum",   32'(bus.out_sum),       32'd1000);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check("t3_release_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("t3_release_in_ready",  {31'd0, bus.in_ready},  32'd1);
        send(13464);
        send(0);
        send(5);
        send(5);
        tick();

        // 4a: clr drops the partial group and the product offered with it
        send(700);
        send(50);
        bus.in_valid = 1'b1;
        bus.in_prod  = 16'd990;
        clr          = 1'b1;
        tick();
        clr          = 1'b0;
        bus.in_valid = 1'b0;
        model_clear();
        check("t4_clr_in_ready",  {31'd0, bus.in_ready},  32'd1);
        check("t4_clr_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("t4_clr_out_sum",   32'(bus.out_sum),       32'd13474);
        send(1);
        send(2);
        send(3);
        send(4);
        tick();

        // 4b: clr discards a pending result even with out_ready=1
        bus.out_ready = 1'b0;
        send(5);
        send(6);
        send(7);
        send(8);
        sb.delete(sb.size() - 1);
        check("t4_pending_valid", {31'd0, bus.out_valid}, 32'd1);
        clr           = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        clr = 1'b0;
        check("t4_discard_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("t4_discard_in_ready",  {31'd0, bus.in_ready},  32'd1);
        check("t4_discard_out_sum",   32'(bus.out_sum),       32'd26);

        // 5: asynchronous reset mid-group
        send(700);
        send(50);
        #2;
        rst = 1'b1;
        #1;
        check("t5_async_in_ready",  {31'd0, bus.in_ready},  32'd0);
        check("t5_async_out_sum",   32'(bus.out_sum),       32'd0);
        check("t5_async_out_valid", {31'd0, bus.out_valid}, 32'd0);
        tick();
        check("t5_held_in_ready", {31'd0, bus.in_ready}, 32'd0);
        model_clear();
        release_reset("t5");
        send(40000);
        send(990);
        send(50);
        send(700);
        tick();
        tick();

        // 6: random gaps inside a group, exactly one result
        rises = 0;
        foreach (sb[i]) check("t6_sb_drained", 32'(sb.size()), 32'd0);
        gap = 0;
        send(10);
        for (int k = 1; k < 4; k++) begin
            gap = $urandom_range(1, 3);
            for (int g = 0; g < gap; g++) begin
                tick();
                check("t6_gap_out_valid", {31'd0, bus.out_valid}, 32'd0);
            end
            send(10 * (k + 1));
        end
        repeat (6) tick();
        check("t6_single_rise", 32'(rises), 32'd1);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_product_accumulator
